// File: rtl/label_sprite_fx.sv
// ============================================================================
//  Module      : label_sprite_fx
//  Description : Bitmap label sprite that slides down into place on frame
//                ticks and can blink once settled; 1-cycle pixel pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module label_sprite_fx #(
    parameter int COLS        = 24,
    parameter int ROWS        = 8,
    parameter int SCALE_SHIFT = 4,
    parameter int POS_X       = 466,
    parameter int POS_Y       = 296,
    parameter int SLIDE_STEP  = 8,
    parameter int BLINK_HALF  = 30,
    parameter logic [ROWS*COLS*2-1:0] BITMAP  = {(ROWS*COLS){2'b01}},
    parameter logic [95:0]            PALETTE = {24'hFFFFFF, 24'hFF0000,
                                                 24'h0000FF, 24'h000000}
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_v_sync,
    input  logic        i_show,
    input  logic        i_blink_en,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_sprite_hit,
    output logic        o_settled
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_slide = 2'd1;
    localparam logic [1:0] c_st_show  = 2'd2;
    localparam logic [1:0] c_st_off   = 2'd3;

    localparam int          CNT_W  = $clog2(BLINK_HALF + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BLINK_HALF - 1);
    localparam logic [16:0] c_x_lo = 17'(POS_X);
    localparam logic [16:0] c_x_hi = 17'(POS_X + (COLS << SCALE_SHIFT));
    localparam logic [16:0] c_h    = 17'(ROWS << SCALE_SHIFT);
    localparam logic [16:0] c_pos_y = 17'(POS_Y);
    localparam logic [16:0] c_step  = 17'(SLIDE_STEP);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [15:0]      r_cur_y;
    logic [15:0]      w_cur_y_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_vsync;
    logic             w_tick;
    logic [16:0]      w_y_sum;

    assign w_tick  = i_v_sync & ~r_vsync;
    assign w_y_sum = {1'b0, r_cur_y} + c_step;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= c_st_idle;
            r_cur_y <= 16'd0;
            r_cnt   <= '0;
            r_vsync <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur_y <= w_cur_y_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vsync <= i_v_sync;
        end
    end

    // Dropping i_show wins over every other transition; cur_y is left alone
    // so the picture never tears mid-frame.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_y_nxt = r_cur_y;
        w_cnt_nxt   = r_cnt;
        if (!i_show) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_tick) begin
                        w_cur_y_nxt = 16'd0;
                        w_state_nxt = c_st_slide;
                    end
                end
                c_st_slide: begin
                    if (w_tick) begin
                        if (w_y_sum >= c_pos_y) begin
                            w_cur_y_nxt = c_pos_y[15:0];
                            w_state_nxt = c_st_show;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cur_y_nxt = w_y_sum[15:0];
                        end
                    end
                end
                default: begin
                    if (r_state == c_st_off && !i_blink_en) begin
                        w_state_nxt = c_st_show;
                        w_cnt_nxt   = '0;
                    end else if (w_tick && i_blink_en) begin
                        if (r_cnt == c_cnt_last) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = (r_state == c_st_show) ? c_st_off : c_st_show;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    logic [16:0] w_x, w_y, w_y_lo, w_y_hi, w_dx, w_dy, w_col, w_row;
    logic        w_in_box;
    logic [31:0] w_cell;
    logic [1:0]  w_idx;
    logic        w_visible;
    logic        w_hit;
    logic [23:0] w_rgb;

    assign w_x      = {1'b0, i_x};
    assign w_y      = {1'b0, i_y};
    assign w_y_lo   = {1'b0, r_cur_y};
    assign w_y_hi   = w_y_lo + c_h;
    assign w_in_box = (w_x >= c_x_lo) && (w_x < c_x_hi) &&
                      (w_y >= w_y_lo) && (w_y < w_y_hi);
    assign w_dx     = w_x - c_x_lo;
    assign w_dy     = w_y - w_y_lo;
    assign w_col    = w_dx >> SCALE_SHIFT;
    assign w_row    = w_dy >> SCALE_SHIFT;

    // Cell index is forced to 0 outside the box so the bitmap select stays in range.
    assign w_cell    = w_in_box ? (32'(w_row) * 32'(COLS) + 32'(w_col)) : 32'd0;
    assign w_idx     = BITMAP[w_cell * 32'd2 +: 2];
    assign w_visible = (r_state == c_st_slide) || (r_state == c_st_show);
    assign w_hit     = w_in_box && (w_idx != 2'd0) && w_visible;
    assign w_rgb     = PALETTE[32'(w_idx) * 32'd24 +: 24];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_sprite_hit <= 1'b0;
            o_red        <= 8'd0;
            o_green      <= 8'd0;
            o_blue       <= 8'd0;
        end else begin
            o_sprite_hit <= w_hit;
            o_red        <= w_hit ? w_rgb[23:16] : 8'd0;
            o_green      <= w_hit ? w_rgb[15:8]  : 8'd0;
            o_blue       <= w_hit ? w_rgb[7:0]   : 8'd0;
        end
    end

    assign o_settled = (r_state == c_st_show) || (r_state == c_st_off);

endmodule

`default_nettype wire

// File: tb/tb_label_sprite_fx.sv
// ============================================================================
//  Module      : tb_label_sprite_fx
//  Description : Self-checking bench for label_sprite_fx (reference model,
//                vector table and directed animation sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_label_sprite_fx;

    localparam int COLS = 24, ROWS = 8, SS = 4, PX = 466, PY = 296;
    localparam int STEP = 8, HALF = 30;
    localparam logic [ROWS*COLS*2-1:0] TB_BITMAP = {64{6'b11_00_01}};
    localparam logic [95:0] TB_PALETTE = {24'hFFFFFF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] x, y;
    logic        vs, show, blink;
    logic [7:0]  red, green, blue;
    logic        hit, settled;

    label_sprite_fx #(
        .COLS(COLS), .ROWS(ROWS), .SCALE_SHIFT(SS), .POS_X(PX), .POS_Y(PY),
        .SLIDE_STEP(STEP), .BLINK_HALF(HALF), .BITMAP(TB_BITMAP), .PALETTE(TB_PALETTE)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_x(x), .i_y(y), .i_v_sync(vs),
        .i_show(show), .i_blink_en(blink), .o_red(red), .o_green(green),
        .o_blue(blue), .o_sprite_hit(hit), .o_settled(settled)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: animation phase, label top row, blink frame count.
    typedef enum int {PH_HIDDEN, PH_SLIDING, PH_ON, PH_OFF} phase_t;
    phase_t m_phase = PH_HIDDEN;
    int     m_top = 0;
    int     m_frames = 0;
    bit     m_prev_vs = 1'b0;

    typedef struct {
        int          px;
        int          py;
        bit          e_hit;
        logic [23:0] e_rgb;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [24:0] ref_pixel(input int px, input int py, input int top, input bit vis);
        int r, c;
        logic [1:0] idx;
        ref_pixel = 25'd0;
        if (px >= PX && px < PX + COLS * (1 << SS) && py >= top && py < top + ROWS * (1 << SS)) begin
            r = (py - top) / (1 << SS);
            c = (px - PX) / (1 << SS);
            idx = TB_BITMAP[(r * COLS + c) * 2 +: 2];
            if (idx != 2'd0 && vis) ref_pixel = {1'b1, TB_PALETTE[idx * 24 +: 24]};
        end
    endfunction

    // One clock: predict outputs from current inputs, advance model, compare.
    task automatic cyc();
        logic [24:0] e_pix;
        bit tick;
        e_pix = rst ? 25'd0 : ref_pixel(int'(x), int'(y), m_top,
                                        m_phase == PH_SLIDING || m_phase == PH_ON);
        if (rst) begin
            m_phase = PH_HIDDEN; m_top = 0; m_frames = 0; m_prev_vs = 1'b0;
        end else begin
            tick = vs && !m_prev_vs;
            m_prev_vs = vs;
            if (!show) m_phase = PH_HIDDEN;
            else if (m_phase == PH_HIDDEN) begin
                if (tick) begin m_top = 0; m_phase = PH_SLIDING; end
            end else if (m_phase == PH_SLIDING) begin
                if (tick) begin
                    m_top = (m_top + STEP < PY) ? m_top + STEP : PY;
                    if (m_top == PY) begin m_phase = PH_ON; m_frames = 0; end
                end
            end else if (m_phase == PH_OFF && !blink) begin
                m_phase = PH_ON; m_frames = 0;
            end else if (tick && blink) begin
                m_frames++;
                if (m_frames == HALF) begin
                    m_frames = 0;
                    m_phase = (m_phase == PH_ON) ? PH_OFF : PH_ON;
                end
            end
        end
        @(posedge clk); #1;
        check("pixel", {7'd0, hit, red, green, blue}, {7'd0, e_pix});
        check("settled", {31'd0, settled}, {31'd0, (m_phase == PH_ON || m_phase == PH_OFF)});
    endtask

    task automatic rand_pix();
        int lo;
        if ($urandom_range(0, 2) == 0) begin
            x = 16'($urandom_range(0, 1023));
            y = 16'($urandom_range(0, 1023));
        end else begin
            lo = (m_top > 8) ? m_top - 8 : 0;
            x = 16'($urandom_range(PX - 8, PX + COLS * 16 + 8));
            y = 16'($urandom_range(lo, m_top + ROWS * 16 + 8));
        end
    endtask

    task automatic frame();
        vs = 1'b1;
        repeat (3) begin rand_pix(); cyc(); end
        vs = 1'b0;
        repeat (3) begin rand_pix(); cyc(); end
    endtask

    task automatic probe(input int px, input int py);
        x = 16'(px); y = 16'(py); cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{466, 296, 1'b1, 24'h0000FF};
        tbl[1]  = '{465, 296, 1'b0, 24'h000000};
        tbl[2]  = '{849, 423, 1'b1, 24'hFFFFFF};
        tbl[3]  = '{850, 424, 1'b0, 24'h000000};
        tbl[4]  = '{850, 423, 1'b0, 24'h000000};
        tbl[5]  = '{849, 424, 1'b0, 24'h000000};
        tbl[6]  = '{482, 296, 1'b0, 24'h000000};
        tbl[7]  = '{498, 296, 1'b1, 24'hFFFFFF};
        tbl[8]  = '{466, 312, 1'b1, 24'h0000FF};
        tbl[9]  = '{466, 295, 1'b0, 24'h000000};
        tbl[10] = '{481, 311, 1'b1, 24'h0000FF};
        tbl[11] = '{514, 296, 1'b1, 24'h0000FF};

        rst = 1'b1; x = 16'd0; y = 16'd0; vs = 1'b0; show = 1'b0; blink = 1'b0;
        repeat (3) cyc();
        check("reset_out", {7'd0, hit, red, green, blue, settled}, 32'd0);
        rst = 1'b0;

        // Slide-in: start tick plus 37 steps reaches the rest position.
        show = 1'b1;
        for (int f = 1; f <= 38; f++) begin
            frame();
            if (f == 37) check("settled_at_37", {31'd0, settled}, 32'd0);
            if (f == 38) check("settled_at_38", {31'd0, settled}, 32'd1);
        end

        foreach (tbl[i]) begin
            probe(tbl[i].px, tbl[i].py);
            check("tbl_hit", {31'd0, hit}, {31'd0, tbl[i].e_hit});
            check("tbl_rgb", {8'd0, red, green, blue}, {8'd0, tbl[i].e_rgb});
        end

        // Blink: 30 ticks off, 30 ticks back on.
        blink = 1'b1;
        repeat (29) frame();
        probe(466, 296);
        check("blink_still_on", {31'd0, hit}, 32'd1);
        frame();
        probe(466, 296);
        check("blink_off_hit", {31'd0, hit}, 32'd0);
        check("blink_off_settled", {31'd0, settled}, 32'd1);
        repeat (30) frame();
        probe(466, 296);
        check("blink_on_hit", {31'd0, hit}, 32'd1);

        // v_sync held high: a single tick only, so no toggle afterwards.
        vs = 1'b1;
        repeat (100) begin rand_pix(); cyc(); end
        vs = 1'b0;
        probe(466, 296);
        check("vs_held_hit", {31'd0, hit}, 32'd1);

        // Go dark again, then drop blink_en: SHOW the cycle after.
        repeat (29) frame();
        probe(466, 296);
        check("off_again", {31'd0, hit}, 32'd0);
        blink = 1'b0;
        probe(466, 296);
        probe(466, 296);
        check("blink_en_drop", {31'd0, hit}, 32'd1);

        // Restart a slide, abort mid-way, then reset.
        show = 1'b0; probe(0, 0);
        show = 1'b1;
        repeat (5) frame();
        probe(466, 32);
        check("slide_pos", {31'd0, hit}, 32'd1);
        show = 1'b0;
        probe(466, 32);
        probe(466, 32);
        check("abort_hit", {31'd0, hit}, 32'd0);
        check("abort_settled", {31'd0, settled}, 32'd0);
        show = 1'b1; rst = 1'b1;
        probe(466, 32);
        check("rst_out", {7'd0, hit, red, green, blue, settled}, 32'd0);
        rst = 1'b0;
        repeat (10) probe(466, 0);
        check("no_tick_idle", {31'd0, hit}, 32'd0);
        frame();
        probe(466, 0);
        check("restart_top0", {31'd0, hit}, 32'd1);

        // Randomized control traffic against the model.
        for (int f = 0; f < 60; f++) begin
            show  = ($urandom_range(0, 9) != 0);
            blink = ($urandom_range(0, 2) != 0);
            frame();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/label_sprite_fx.md
LABEL_SPRITE_FX -- requirements
Module: label_sprite_fx

Interface
REQ-001 SHALL provide parameter COLS, default 24, bitmap columns.
REQ-002 SHALL provide parameter ROWS, default 8, bitmap rows.
REQ-003 SHALL provide parameter SCALE_SHIFT, default 4; each bitmap cell is a (1<<SCALE_SHIFT)-pixel square.
REQ-004 SHALL provide parameters POS_X, default 466, and POS_Y, default 296, the final top-left screen position.
REQ-005 SHALL provide parameter SLIDE_STEP, default 8, the pixels moved per frame during slide-in.
REQ-006 SHALL provide parameter BLINK_HALF, default 30, the frames per blink half-period.
REQ-007 SHALL provide parameter BITMAP, width ROWS*COLS*2; cell (r,c) is a 2-bit palette index at bit offset (r*COLS+c)*2.
REQ-008 SHALL provide parameter PALETTE, width 96; entry k sits at bit offset k*24, ordered red [23:16], green [15:8], blue [7:0]; index 0 is transparent.
REQ-009 i_clk  in  1  sole clock; every register updates on its rising edge.
REQ-010 i_reset  in  1  synchronous, active-high reset.
REQ-011 i_x  in  16  current pixel column.
REQ-012 i_y  in  16  current pixel row.
REQ-013 i_v_sync  in  1  vertical sync, level.
REQ-014 i_show  in  1  request label visible.
REQ-015 i_blink_en  in  1  enable blinking once settled.
REQ-016 o_red, o_green, o_blue  out  8 each  registered pixel colour.
REQ-017 o_sprite_hit  out  1  registered opaque-pixel flag.
REQ-018 o_settled  out  1  high in SHOW or BLINK_OFF.

Function
REQ-019 SHALL register i_v_sync and generate a one-cycle frame tick on each 0->1 transition.
REQ-020 SHALL implement a state machine with states IDLE, SLIDE, SHOW and BLINK_OFF.
REQ-021 IDLE: when i_show=1 at a frame tick, the block SHALL set cur_y=0 and enter SLIDE.
REQ-022 SLIDE: on each frame tick, cur_y SHALL become min(cur_y+SLIDE_STEP, POS_Y); reaching POS_Y SHALL enter SHOW in the same update, with the blink counter cleared.
REQ-023 SHOW: with i_blink_en=1, each frame tick SHALL increment the blink counter; on a tick where the counter equals BLINK_HALF-1, the counter SHALL clear and the state SHALL toggle SHOW<->BLINK_OFF.
REQ-024 BLINK_OFF: if i_blink_en=0, the block SHALL return to SHOW on the next cycle with the counter cleared.
REQ-025 In any state, i_show=0 SHALL force IDLE on the next cycle, regardless of frame tick; this takes priority over all other transitions.
REQ-026 cur_y SHALL change only on frame ticks, except under REQ-021 and reset, so no frame tears.
REQ-027 Box hit SHALL be POS_X <= i_x < POS_X+(COLS<<SCALE_SHIFT) and cur_y <= i_y < cur_y+(ROWS<<SCALE_SHIFT), computed in 17-bit unsigned with no wrap.
REQ-028 Cell SHALL be c=(i_x-POS_X)>>SCALE_SHIFT and r=(i_y-cur_y)>>SCALE_SHIFT; both are evaluated only when inside the box.
REQ-029 Visible SHALL be true in SLIDE and SHOW and false in IDLE and BLINK_OFF.
REQ-030 One cycle after i_x/i_y are presented, o_sprite_hit SHALL equal box-hit AND index!=0 AND visible.
REQ-031 The colour outputs SHALL carry the palette entry when o_sprite_hit=1, else 0; outputs SHALL never be X.
REQ-032 Latency from i_x/i_y to all outputs SHALL be exactly 1 cycle, with full throughput of one pixel per cycle.

Reset
REQ-033 When i_reset=1, at the next edge: state=IDLE, cur_y=0, blink counter=0, registered v_sync=0, all outputs=0.
REQ-034 Reset mid-slide or mid-blink SHALL abandon the animation; after release, a new slide requires i_show=1 at a frame tick.

Verification
REQ-035 Defaults, i_show=1, 37 frame ticks -> cur_y steps 0,8,...,296; SHOW entered at tick 38 counting the start tick; o_settled=1.
REQ-036 Settled, pixel (466,296) where cell (0,0)=1 and PALETTE[1]=0000FF -> next cycle o_sprite_hit=1, RGB=00/00/FF; pixel (465,296) -> hit=0, RGB=0.
REQ-037 Settled, i_blink_en=1 -> BLINK_OFF after 30 ticks with hit=0 on opaque pixels, SHOW again after 30 more.
REQ-038 Slide in progress, i_show=0 -> IDLE next cycle, hit=0; then i_reset pulse -> all outputs 0, cur_y=0.
REQ-039 Pixel (849,423) (last cell) and (850,424) -> first inside the box, second outside; v_sync held high -> no additional ticks.
